noc_pe_node: RTL

NOC_PE_NODE -- requirements
Module: noc_pe_node

---
 rtl/noc_pe_node.sv | 123 ++++++++++++
 1 files changed

// File: rtl/noc_pe_node.sv
// PE network interface: credit-gated injection FIFO toward the router, always-accepting ejection path.
// Optional NOC_PE_STATS_EN adds 16-bit wrapping tx/rx flit counters.
module noc_pe_node #(
  parameter int DATA_W     = 20,
  parameter int CREDIT_MAX = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              out_valid,
  input  logic              ci,
  input  logic [DATA_W-1:0] datain,
  input  logic              in_valid,
  output logic              co,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              credit_err
`ifdef NOC_PE_STATS_EN
  ,
  output logic [15:0]       tx_count,
  output logic [15:0]       rx_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CREDIT_MAX + 1);
  localparam logic [CW-1:0] C_MAX = CW'(CREDIT_MAX);
  localparam logic [AW:0]   F_MAX = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;
  logic [CW-1:0]     r_credit;
  logic [DATA_W-1:0] r_dataout, r_rx_data;
  logic              r_out_valid, r_rx_valid, r_co, r_credit_err;

  logic w_full, w_empty, w_push, w_send;

  // Occupancy is registered, so a flit pushed into an empty FIFO is not poppable until the next cycle.
  assign w_full   = (r_count == F_MAX);
  assign w_empty  = (r_count == '0);
  assign w_push   = tx_valid && !w_full;
  assign w_send   = !w_empty && (r_credit != '0);
  assign tx_ready = !w_full;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_credit     <= C_MAX;
      r_dataout    <= '0;
      r_out_valid  <= 1'b0;
      r_credit_err <= 1'b0;
    end else begin
      r_out_valid <= w_send;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_send) begin
        r_rptr    <= r_rptr + AW'(1);
        r_dataout <= r_mem[r_rptr];
      end
      case ({w_push, w_send})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      // A credit returned while already full is dropped and flagged until reset.
      case ({w_send, ci})
        2'b10:   r_credit <= r_credit - CW'(1);
        2'b01: begin
          if (r_credit == C_MAX) r_credit_err <= 1'b1;
          else                   r_credit <= r_credit + CW'(1);
        end
        default: r_credit <= r_credit;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_co       <= 1'b0;
    end else begin
      r_rx_valid <= in_valid;
      r_co       <= in_valid;
      if (in_valid) r_rx_data <= datain;
    end
  end

`ifdef NOC_PE_STATS_EN
  logic [15:0] r_tx_count, r_rx_count;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_tx_count <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_send)   r_tx_count <= r_tx_count + 16'd1;
      if (in_valid) r_rx_count <= r_rx_count + 16'd1;
    end
  end

  assign tx_count = r_tx_count;
  assign rx_count = r_rx_count;
`endif

  assign dataout    = r_dataout;
  assign out_valid  = r_out_valid;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign co         = r_co;
  assign credit_err = r_credit_err;

endmodule
